// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the instruction-fetch responder.
// Provides the FSM state enum, the NOP instruction returned on faulting
// fetches, and the default parameter values used by fetch_responder.
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} fetch_state_e;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int ADDR_W_DEF = 32;
   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF = 1024;
   localparam int WAIT_CYCLES_DEF = 2;
endpackage

// File: rtl/fetch_store.sv
// fetch_store: instruction word array, one synchronous write port and one
// combinational read port (the caller registers the read result).
// Ports: clk; we/waddr/wdata write port; raddr/rdata read port.
// Contents are not reset.
module fetch_store #(
   parameter int DEPTH = 1024,
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [DATA_W-1:0]        wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [DATA_W-1:0]        rdata
);
   logic [DATA_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/fetch_responder.sv
// fetch_responder: memory-side end of the F-stage fetch interface.
// Accepts word fetches on req_valid_i/req_ready_o, waits WAIT_CYCLES, then
// presents rsp_data_o/rsp_err_o with rsp_valid_o until rsp_ready_i.
// flush_i discards an in-flight fetch only when FETCH_RESPONDER_FLUSH_EN
// is defined; otherwise it is ignored. ld_we_i/ld_addr_i/ld_data_i fill
// the instruction store. clk_i rising edge; reset_i async active-high.
module fetch_responder
   import fetch_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     req_valid_i,
   input  logic [ADDR_W-1:0]        req_addr_i,
   output logic                     req_ready_o,
   output logic                     rsp_valid_o,
   output logic [DATA_W-1:0]        rsp_data_o,
   output logic                     rsp_err_o,
   input  logic                     rsp_ready_i,
   input  logic                     flush_i,
   input  logic                     ld_we_i,
   input  logic [$clog2(DEPTH)-1:0] ld_addr_i,
   input  logic [DATA_W-1:0]        ld_data_i
);
   localparam int AW = $clog2(DEPTH);
`ifdef FETCH_RESPONDER_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif
   fetch_state_e state;
   logic [3:0] cnt;
   logic [ADDR_W-1:0] addr_q, addr;
   logic [DATA_W-1:0] rd_data;
   logic flush, err, accept, enter;
   assign flush = FLUSH_EN & flush_i;
   assign req_ready_o = (state == IDLE) & ~flush;
   assign accept = req_valid_i & req_ready_o;
   // With zero wait states the accepting edge is also the RESP-entry edge,
   // so the lookup must use the live request address while idle.
   assign addr = (state == IDLE) ? req_addr_i : addr_q;
   assign err = (addr[1:0] != 2'd0) | (|addr[ADDR_W-1:AW+2]);
   assign enter = (accept & (WAIT_CYCLES == 0)) | ((state == WAIT) & (cnt == 4'd0));
   fetch_store #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_store (
      .clk(clk_i),
      .we(ld_we_i),
      .waddr(ld_addr_i),
      .wdata(ld_data_i),
      .raddr(addr[AW+1:2]),
      .rdata(rd_data)
   );
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state <= IDLE;
         cnt <= 4'd0;
         addr_q <= '0;
         rsp_valid_o <= 1'b0;
         rsp_data_o <= '0;
         rsp_err_o <= 1'b0;
      end else if (flush && state != IDLE) begin
         state <= IDLE;
         rsp_valid_o <= 1'b0;
      end else begin
         if (accept) addr_q <= req_addr_i;
         if (accept && WAIT_CYCLES != 0) begin
            state <= WAIT;
            cnt <= 4'(WAIT_CYCLES - 1);
         end
         if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
         // Store read is sampled here, so a same-edge load write is not seen.
         if (enter) begin
            state <= RESP;
            rsp_valid_o <= 1'b1;
            rsp_err_o <= err;
            rsp_data_o <= err ? DATA_W'(NOP_INSTR) : rd_data;
         end
         if (state == RESP && rsp_ready_i) begin
            state <= IDLE;
            rsp_valid_o <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: randomized self-checking bench for fetch_responder.
// Instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0; both share
// reset, flush and the load port, and are checked against a word-array model.
module tb_fetch_responder;
   localparam int DEPTH = 1024;
   localparam logic [31:0] NOP = 32'h0000_0013;
   logic clk = 1'b0;
   logic reset_i = 1'b1;
   logic flush = 1'b0;
   logic ld_we = 1'b0;
   logic [9:0] ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic [1:0] req_valid = '0, rsp_ready = '0, req_ready, rsp_valid, rsp_err;
   logic [31:0] req_addr [2];
   logic [31:0] rsp_data [2];
   logic [31:0] mem_m [DEPTH];
   int n_chk = 0, n_pass = 0;
   always #5 clk = ~clk;

   fetch_responder dut0 (
      .clk_i(clk), .reset_i(reset_i), .req_valid_i(req_valid[0]), .req_addr_i(req_addr[0]),
      .req_ready_o(req_ready[0]), .rsp_valid_o(rsp_valid[0]), .rsp_data_o(rsp_data[0]),
      .rsp_err_o(rsp_err[0]), .rsp_ready_i(rsp_ready[0]), .flush_i(flush),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
   );
   fetch_responder #(.WAIT_CYCLES(0)) dut1 (
      .clk_i(clk), .reset_i(reset_i), .req_valid_i(req_valid[1]), .req_addr_i(req_addr[1]),
      .req_ready_o(req_ready[1]), .rsp_valid_o(rsp_valid[1]), .rsp_data_o(rsp_data[1]),
      .rsp_err_o(rsp_err[1]), .rsp_ready_i(rsp_ready[1]), .flush_i(flush),
      .ld_we_i(ld_we), .ld_addr_i(ld_addr), .ld_data_i(ld_data)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic is_err(input logic [31:0] a);
      return (a % 4 != 0) || (a / 4 >= DEPTH);
   endfunction

   function automatic logic [31:0] exp_data(input logic [31:0] a);
      return is_err(a) ? NOP : mem_m[a / 4];
   endfunction

   // Wait (bounded) for a response, check it, then consume it.
   task automatic finish_rsp(input int s, input logic [31:0] ed, input logic ee);
      int n = 0;
      forever begin
         @(negedge clk);
         if (rsp_valid[s] || n > 20) break;
         @(posedge clk);
         n++;
      end
      chk("rsp_valid", {31'd0, rsp_valid[s]}, 32'd1);
      chk("rsp_data", rsp_data[s], ed);
      chk("rsp_err", {31'd0, rsp_err[s]}, {31'd0, ee});
      rsp_ready[s] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[s] = 1'b0;
      @(negedge clk);
      chk("consumed_valid", {31'd0, rsp_valid[s]}, 32'd0);
   endtask

   // One complete fetch on instance s, optionally writing v to the same word
   // on the RESP-entry edge; the response must still carry the old word.
   task automatic fetch(input int s, input logic [31:0] a, input int hold, input bit ld, input logic [31:0] v);
      logic [31:0] ed;
      logic ee;
      int n, lat;
      lat = (s == 0) ? 3 : 1;
      ee = is_err(a);
      ed = exp_data(a);
      @(negedge clk);
      chk("ready_idle", {31'd0, req_ready[s]}, 32'd1);
      req_valid[s] = 1'b1;
      req_addr[s] = a;
      @(posedge clk);
      #1 req_valid[s] = 1'b0;
      n = 1;
      forever begin
         @(negedge clk);
         if (rsp_valid[s] || n > 20) break;
         chk("busy_ready", {31'd0, req_ready[s]}, 32'd0);
         if (ld && n == lat - 1) begin
            ld_we = 1'b1;
            ld_addr = a[11:2];
            ld_data = v;
         end
         @(posedge clk);
         #1 ld_we = 1'b0;
         n++;
      end
      if (ld) mem_m[a[11:2]] = v;
      chk("latency", n, lat);
      chk("rsp_data", rsp_data[s], ed);
      chk("rsp_err", {31'd0, rsp_err[s]}, {31'd0, ee});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("hold_valid", {31'd0, rsp_valid[s]}, 32'd1);
         chk("hold_data", rsp_data[s], ed);
         chk("hold_err", {31'd0, rsp_err[s]}, {31'd0, ee});
         chk("hold_ready", {31'd0, req_ready[s]}, 32'd0);
      end
      rsp_ready[s] = 1'b1;
      @(posedge clk);
      #1 rsp_ready[s] = 1'b0;
      @(negedge clk);
      chk("consumed_valid", {31'd0, rsp_valid[s]}, 32'd0);
      chk("consumed_ready", {31'd0, req_ready[s]}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] a;
      req_addr[0] = '0;
      req_addr[1] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         chk("reset_valid", {31'd0, rsp_valid[s]}, 32'd0);
         chk("reset_data", rsp_data[s], 32'd0);
         chk("reset_err", {31'd0, rsp_err[s]}, 32'd0);
      end
      reset_i = 1'b0;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         ld_we = 1'b1;
         ld_addr = 10'(i);
         ld_data = (i == 4) ? 32'hDEAD_BEEF : $urandom;
         mem_m[i] = ld_data;
      end
      @(negedge clk);
      ld_we = 1'b0;
      fetch(0, 32'h10, 0, 1'b0, '0);
      fetch(0, 32'h12, 0, 1'b0, '0);
      fetch(0, DEPTH * 4, 0, 1'b0, '0);
      fetch(0, 32'h14, 5, 1'b0, '0);
      fetch(1, 32'h10, 1, 1'b0, '0);
      // flush while waiting
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_addr[0] = 32'h18;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
`ifdef FETCH_RESPONDER_FLUSH_EN
      repeat (4) begin
         @(negedge clk);
         chk("flush_wait_valid", {31'd0, rsp_valid[0]}, 32'd0);
         chk("flush_wait_ready", {31'd0, req_ready[0]}, 32'd1);
      end
`else
      finish_rsp(0, mem_m[6], 1'b0);
`endif
      // flush while idle with a request presented
      @(negedge clk);
      flush = 1'b1;
      req_valid[0] = 1'b1;
      req_addr[0] = 32'h1C;
      #1;
`ifdef FETCH_RESPONDER_FLUSH_EN
      chk("flush_idle_ready", {31'd0, req_ready[0]}, 32'd0);
`else
      chk("flush_idle_ready", {31'd0, req_ready[0]}, 32'd1);
`endif
      @(posedge clk);
      #1 flush = 1'b0;
      req_valid[0] = 1'b0;
`ifdef FETCH_RESPONDER_FLUSH_EN
      repeat (4) begin
         @(negedge clk);
         chk("flush_idle_valid", {31'd0, rsp_valid[0]}, 32'd0);
      end
`else
      finish_rsp(0, mem_m[7], 1'b0);
`endif
      fetch(0, 32'h10, 0, 1'b1, 32'h1111_1111);
      fetch(0, 32'h10, 0, 1'b0, '0);
      // async reset in the middle of WAIT
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_addr[0] = 32'h20;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      #2 reset_i = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, rsp_valid[0]}, 32'd0);
      chk("async_rst_data", rsp_data[0], 32'd0);
      chk("async_rst_ready", {31'd0, req_ready[0]}, 32'd1);
      @(negedge clk);
      reset_i = 1'b0;
      fetch(0, 32'h20, 0, 1'b0, '0);
      fetch(1, 32'h20, 0, 1'b0, '0);
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 3))
            0, 1: a = 32'($urandom_range(0, 63)) * 4;
            2: a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
            default: a = $urandom | 32'h0000_1000;
         endcase
         fetch(int'($urandom_range(0, 1)), a, int'($urandom_range(0, 3)), 1'b0, '0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
